// File: rtl/plab4_net_sched_pkg.sv
// Shared types for the TDM output scheduler: FSM states, domain tags, port index.
package plab4_net_sched_pkg;

   typedef enum logic [1:0] {
      EPOCH_D0 = 2'd0,
      GUARD_D0 = 2'd1,
      EPOCH_D1 = 2'd2,
      GUARD_D1 = 2'd3
   } sched_state_t;

   localparam logic DOM_LOW  = 1'b0;
   localparam logic DOM_HIGH = 1'b1;

   typedef logic [1:0] port_idx_t;

   // Successor in the 0 -> 1 -> 2 -> 0 search order; 3 behaves as 0.
   function automatic port_idx_t next_port(input port_idx_t k);
      case (k)
         2'd0:    return 2'd1;
         2'd1:    return 2'd2;
         2'd2:    return 2'd0;
         default: return 2'd1;
      endcase
   endfunction

endpackage

// File: rtl/plab4_net_RRPtrArb3.sv
// Combinational 3-way round-robin pick: first eligible port at or after ptr.
// Zero latency; no state, pointer ownership stays with the caller.
module plab4_net_RRPtrArb3
   import plab4_net_sched_pkg::*;
(
   input  logic [2:0] eligible,
   input  port_idx_t  ptr,
   output logic [2:0] grant,
   output port_idx_t  idx,
   output logic       any
);

   port_idx_t  cand;
   logic [2:0] sh;

   always_comb begin
      grant = 3'b000;
      idx   = 2'd0;
      any   = 1'b0;
      cand  = (ptr == 2'd3) ? 2'd0 : ptr;
      sh    = 3'b000;
      for (int o = 0; o < 3; o++) begin
         sh = 3'b001 << cand;
         if (!any && ((eligible & sh) != 3'b000)) begin
            any   = 1'b1;
            idx   = cand;
            grant = sh;
         end
         cand = next_port(cand);
      end
   end

endmodule

// File: rtl/plab4_net_router_output_sched_tdm.sv
// TDM output scheduler: zero-latency grants within per-domain epochs; out_rdy low suppresses
// grants and holds pointers. Idle guard states compiled in by PLAB4_NET_SCHED_GUARD_EN.
module plab4_net_router_output_sched_tdm
   import plab4_net_sched_pkg::*;
#(
   parameter int unsigned p_epoch_len = 8,
   parameter int unsigned p_guard_len = 1
)(
   input  logic       clk,
   input  logic       reset,
   input  logic       reqs_p0,
   input  logic       reqs_p1,
   input  logic       reqs_p2,
   input  logic       reqs_p0_domain,
   input  logic       reqs_p1_domain,
   input  logic       reqs_p2_domain,
   input  logic       out_rdy,
   output logic       grants_p0,
   output logic       grants_p1,
   output logic       grants_p2,
   output logic       out_val,
   output logic [1:0] xbar_sel,
   output logic       out_domain,
   output logic       epoch_active
);

   localparam int unsigned CNT_MAX = (p_epoch_len > p_guard_len) ? p_epoch_len : p_guard_len;
   localparam int unsigned CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
   localparam logic [CW-1:0] EPOCH_LAST = CW'(p_epoch_len - 1);
`ifdef PLAB4_NET_SCHED_GUARD_EN
   localparam logic [CW-1:0] GUARD_LAST = CW'(p_guard_len - 1);
`endif

   sched_state_t  state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   port_idx_t     ptr_d0_q, ptr_d0_d;
   port_idx_t     ptr_d1_q, ptr_d1_d;

   logic          active_dom;
   logic          in_epoch;
   logic [2:0]    eligible;
   logic [2:0]    arb_grant;
   port_idx_t     arb_idx;
   logic          arb_any;
   port_idx_t     arb_ptr;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= EPOCH_D0;
         cnt_q    <= '0;
         ptr_d0_q <= 2'd0;
         ptr_d1_q <= 2'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_d0_q <= ptr_d0_d;
         ptr_d1_q <= ptr_d1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + 1'b1;
      case (state_q)
         EPOCH_D0: if (cnt_q == EPOCH_LAST) begin
`ifdef PLAB4_NET_SCHED_GUARD_EN
            state_d = GUARD_D0;
`else
            state_d = EPOCH_D1;
`endif
            cnt_d   = '0;
         end
         EPOCH_D1: if (cnt_q == EPOCH_LAST) begin
`ifdef PLAB4_NET_SCHED_GUARD_EN
            state_d = GUARD_D1;
`else
            state_d = EPOCH_D0;
`endif
            cnt_d   = '0;
         end
`ifdef PLAB4_NET_SCHED_GUARD_EN
         GUARD_D0: if (cnt_q == GUARD_LAST) begin
            state_d = EPOCH_D1;
            cnt_d   = '0;
         end
         GUARD_D1: if (cnt_q == GUARD_LAST) begin
            state_d = EPOCH_D0;
            cnt_d   = '0;
         end
`endif
         default: begin
            state_d = EPOCH_D0;
            cnt_d   = '0;
         end
      endcase
   end

   assign active_dom = (state_q == EPOCH_D1 || state_q == GUARD_D1) ? DOM_HIGH : DOM_LOW;
   assign in_epoch   = (state_q == EPOCH_D0 || state_q == EPOCH_D1);

   // Masking with reset makes grants drop the instant reset rises, not at the next edge.
   assign eligible = {reqs_p2 && (reqs_p2_domain == active_dom),
                      reqs_p1 && (reqs_p1_domain == active_dom),
                      reqs_p0 && (reqs_p0_domain == active_dom)}
                     & {3{out_rdy && in_epoch && !reset}};

   assign arb_ptr = (active_dom == DOM_HIGH) ? ptr_d1_q : ptr_d0_q;

   plab4_net_RRPtrArb3 u_arb (
      .eligible (eligible),
      .ptr      (arb_ptr),
      .grant    (arb_grant),
      .idx      (arb_idx),
      .any      (arb_any)
   );

   always_comb begin
      ptr_d0_d = ptr_d0_q;
      ptr_d1_d = ptr_d1_q;
      if (arb_any) begin
         if (active_dom == DOM_HIGH) ptr_d1_d = next_port(arb_idx);
         else                        ptr_d0_d = next_port(arb_idx);
      end
   end

   assign grants_p0  = arb_grant[0];
   assign grants_p1  = arb_grant[1];
   assign grants_p2  = arb_grant[2];
   assign out_val    = arb_any;
   assign xbar_sel   = arb_idx;
   assign out_domain = active_dom;
`ifdef PLAB4_NET_SCHED_GUARD_EN
   assign epoch_active = in_epoch;
`else
   assign epoch_active = 1'b1;
`endif

endmodule

// File: doc/plab4_net_router_output_sched_tdm.md
# plab4_net_router_output_sched_tdm

Time-division scheduler for one router output port shared by two security domains (0 = low, 1 = high). It alternates fixed-length epochs between domains. Within an epoch it round-robins only among input ports whose request domain matches the active domain, and it drives grants, out_val, xbar_sel and out_domain to the output crossbar. Grant timing and arbitration state of one domain are independent of the other domain's traffic. It replaces the purely combinational output control in the secure router build.

## Interface
- p_epoch_len, 8 — cycles per domain epoch; must be ≥ 2.
- p_guard_len, 1 — idle guard cycles after each epoch; must be ≥ 1 when the guard is compiled in.
- clk  input  1  clock, rising-edge
- reset  input  1  asynchronous, active-high
- reqs_p0 / reqs_p1 / reqs_p2  input  1 each  per-port request
- reqs_p0_domain / reqs_p1_domain / reqs_p2_domain  input  1 each  domain tag of each request
- out_rdy  input  1  downstream ready
- grants_p0 / grants_p1 / grants_p2  output  1 each  one-hot grant
- out_val  output  1  OR of the grants
- xbar_sel  output  2  selected port: 0, 1 or 2; 0 when no grant
- out_domain  output  1  active domain of the current epoch or guard
- epoch_active  output  1  high during an epoch, low during a guard

## Operation
- FSM states: EPOCH_D0 → GUARD_D0 → EPOCH_D1 → GUARD_D1 → EPOCH_D0.
- Cycle counter `cnt` is cleared on every state change and increments every cycle.
- EPOCH leaves when `cnt == p_epoch_len-1`. GUARD leaves when `cnt == p_guard_len-1`.
- Eligible set for port i in EPOCH_Dd: `reqs_pi && reqs_pi_domain == d && out_rdy`. In GUARD states the eligible set is empty.
- Each domain has its own 2-bit priority pointer, `ptr_d0` and `ptr_d1`.
- The winner is the first eligible port at or after the active domain's pointer, searching 0 → 1 → 2 → 0.
- On a grant to port k, the active domain's pointer becomes `(k+1) mod 3`. The other domain's pointer never changes.
- With no grant, all pointers hold.
- xbar_sel = index of the granted port. out_val = any grant.
- out_domain = d in EPOCH_Dd and in GUARD_Dd.
- A request with a mismatched domain tag is never granted in that epoch. It waits for its own domain's epoch.
- out_rdy low → no grant that cycle; pointers hold.
- Out-of-range pointer value 3 is treated as 0.

## Timing
- Grants are combinational from the registered state plus the current-cycle inputs, with zero latency. The pointer updates on the next rising edge.
- A request present in the last epoch cycle is granted in that cycle. From the first guard cycle onward it gets nothing.
- Frame period: `2*(p_epoch_len + p_guard_len)` cycles, independent of traffic.
- Reset value of every output: all grants 0, out_val 0, xbar_sel 0, out_domain 0, epoch_active 1.
- Reset state: EPOCH_D0, cnt 0, both pointers 0.
- Asserting reset mid-epoch forces the outputs to their reset values immediately; the FSM restarts in EPOCH_D0 with cnt 0.
- When reset deasserts, the first cycle is cycle 0 of EPOCH_D0.
- cnt width: `$clog2(max(p_epoch_len, p_guard_len))`, saturating not required.

## Configuration
- Macro: `PLAB4_NET_SCHED_GUARD_EN`.
- Defined: guard states exist as specified.
- Undefined: the GUARD states are removed. EPOCH_D0 goes directly to EPOCH_D1 and back, the frame period is `2*p_epoch_len`, epoch_active is tied to 1, and p_guard_len is ignored.

## Structure
- Package `plab4_net_sched_pkg`: FSM state encoding, domain constants DOM_LOW = 0 and DOM_HIGH = 1, and a port-index typedef (2 bits).
- Sub-module `plab4_net_RRPtrArb3`: combinational 3-way round-robin pick.
  - Inputs: eligible[2:0], ptr[1:0].
  - Outputs: grant[2:0] one-hot, idx[1:0], any.
- The top level holds the FSM, counter and pointer registers, and instantiates one `plab4_net_RRPtrArb3`. Its ptr input is muxed by the active domain.

## Test plan
- Reset, then idle for 20 cycles (p_epoch_len=8, p_guard_len=1) → epoch_active low exactly at cycles 8 and 17; out_domain 0 for cycles 0–8 and 1 for cycles 9–17; no grants.
- p0, p1, p2 all requesting with domain 0 and out_rdy=1 throughout EPOCH_D0 → grants p0, p1, p2, p0, … over cycles 0–7, with xbar_sel matching; no grants in cycles 8–17.
- p1 requesting with domain 1 from cycle 0 → first grant at cycle 9; out_domain=1 at that cycle.
- Heavy domain-1 traffic interleaved with a single domain-0 requester on p2 → ptr_d0 is unchanged by the domain-1 grants, and the p2 grant cycle in epoch 0 is identical with and without the domain-1 traffic.
- out_rdy held low for cycles 2–4 with p0 requesting in domain 0 → no grants and out_val 0 in those cycles; pointer holds; grant resumes at cycle 5.
- Reset asserted asynchronously at cycle 5 during a grant → outputs zero immediately; after release the FSM restarts in EPOCH_D0 at cnt 0 with ptr_d0=0.
